// File: rtl/rt_sb_pkg.sv
// Shared scoreboard types for DE, WB and the writeback scoreboard.
// Register address widths and the per-register entry layout live here.
package rt_sb_pkg;
  localparam int SREG_AW = 5;
  localparam int VREG_AW = 4;
  localparam int CNT_W   = 2;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef logic [SREG_AW-1:0] sreg_addr_t;
  typedef logic [VREG_AW-1:0] vreg_addr_t;

  typedef struct packed {
    logic [CNT_W-1:0] cnt;
    logic             late;
  } sb_entry_t;

  function automatic logic cnt_sat(input logic [CNT_W-1:0] c);
    return c == CNT_MAX;
  endfunction
endpackage

// File: rtl/wb_scoreboard_bank.sv
// One register bank of the scoreboard: outstanding-write counters and late flags,
// the hazard lookup for the DE operands, and next-cycle busy / error events.
module sb_bank
  import rt_sb_pkg::*;
#(
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] rd1_addr,
  input  logic [AW-1:0] rd2_addr,
  input  logic          rd1_cnt_chk,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  input  logic          issue,
  input  logic          wr_late,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_addr,
  input  logic          ret_en,
  input  logic [AW-1:0] ret_addr,
  output logic          hazard,
  output logic          busy_nxt,
  output logic          err_evt
);
  localparam logic [AW-1:0] ADDR_ZERO = {AW{1'b0}};

  sb_entry_t ent_r   [NREG];
  sb_entry_t ent_nxt [NREG];

  logic do_inc;
  logic do_dec;

  assign do_inc = issue && (wr_addr != ADDR_ZERO);
  assign do_dec = ret_en && (ret_addr != ADDR_ZERO);

  // Register 0 never stalls: its entry stays at reset value forever.
  assign hazard = ((rd1_addr != ADDR_ZERO) && ent_r[rd1_addr].late)
               || ((rd2_addr != ADDR_ZERO) && ent_r[rd2_addr].late)
               || (rd1_cnt_chk && (ent_r[rd1_addr].cnt != CNT_ZERO))
               || (wr_req && (wr_addr != ADDR_ZERO) && cnt_sat(ent_r[wr_addr].cnt));

  // Next-state of every entry from issue, late-clear and retire.
  always_comb begin
    ent_nxt  = ent_r;
    busy_nxt = 1'b0;
    err_evt  = do_dec && (ent_r[ret_addr].cnt == CNT_ZERO);
    for (int i = 1; i < NREG; i++) begin
      if (do_inc && (wr_addr == AW'(i)) && !(do_dec && (ret_addr == AW'(i)))) begin
        if (!cnt_sat(ent_r[i].cnt)) begin
          ent_nxt[i].cnt = ent_r[i].cnt + CNT_ONE;
        end else begin
          ent_nxt[i].cnt = ent_r[i].cnt;
        end
      end else if (do_dec && (ret_addr == AW'(i)) && !(do_inc && (wr_addr == AW'(i)))) begin
        if (ent_r[i].cnt != CNT_ZERO) begin
          ent_nxt[i].cnt = ent_r[i].cnt - CNT_ONE;
        end else begin
          ent_nxt[i].cnt = ent_r[i].cnt;
        end
      end else begin
        ent_nxt[i].cnt = ent_r[i].cnt;
      end
      // A late issue belongs to the younger instruction, so it wins over a clear.
      if (do_inc && wr_late && (wr_addr == AW'(i))) begin
        ent_nxt[i].late = 1'b1;
      end else if (clr_en && (clr_addr == AW'(i))) begin
        ent_nxt[i].late = 1'b0;
      end else begin
        ent_nxt[i].late = ent_r[i].late;
      end
      busy_nxt = busy_nxt | (ent_nxt[i].cnt != CNT_ZERO);
    end
  end

  // Entry storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        ent_r[i] <= '{cnt: CNT_ZERO, late: 1'b0};
      end
    end else begin
      ent_r <= ent_nxt;
    end
  end
endmodule

// File: rtl/wb_scoreboard.sv
// Writeback scoreboard beside the DE stage: tracks outstanding scalar and vector
// writes and stalls DE when an operand cannot be forwarded in time.
module wb_scoreboard
  import rt_sb_pkg::*;
#(
  parameter int NUM_SREG = 32,
  parameter int NUM_VREG = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               de_valid,
  input  logic               flush,
  input  logic [SREG_AW-1:0] de_s1_addr,
  input  logic [SREG_AW-1:0] de_s2_addr,
  input  logic [VREG_AW-1:0] de_v1_addr,
  input  logic [VREG_AW-1:0] de_v2_addr,
  input  logic               link_en,
  input  logic               de_swb_en,
  input  logic [SREG_AW-1:0] de_swb_addr,
  input  logic               de_vwb_en,
  input  logic [VREG_AW-1:0] de_vwb_addr,
  input  logic               de_late,
  input  logic               mem_s_done,
  input  logic [SREG_AW-1:0] mem_s_addr,
  input  logic               mem_v_done,
  input  logic [VREG_AW-1:0] mem_v_addr,
  input  logic               wb_swb_en,
  input  logic [SREG_AW-1:0] wb_swb_addr,
  input  logic               wb_vwb_en,
  input  logic [VREG_AW-1:0] wb_vwb_addr,
  output logic               de_stall,
  output logic               sb_busy,
  output logic               sb_err
);
  logic s_hazard, v_hazard;
  logic s_busy, v_busy;
  logic s_err, v_err;
  logic issue;
  logic sb_busy_r, sb_err_r;

  assign de_stall = de_valid & (s_hazard | v_hazard);
  assign issue    = de_valid & ~de_stall & ~flush;
  assign sb_busy  = sb_busy_r;
  assign sb_err   = sb_err_r;

  sb_bank #(.NREG(NUM_SREG), .AW(SREG_AW)) u_sbank (
    .clk(clk), .rst(rst),
    .rd1_addr(de_s1_addr), .rd2_addr(de_s2_addr), .rd1_cnt_chk(link_en),
    .wr_req(de_swb_en), .wr_addr(de_swb_addr), .issue(issue & de_swb_en), .wr_late(de_late),
    .clr_en(mem_s_done), .clr_addr(mem_s_addr),
    .ret_en(wb_swb_en), .ret_addr(wb_swb_addr),
    .hazard(s_hazard), .busy_nxt(s_busy), .err_evt(s_err)
  );

  // The link register is scalar, so the vector bank never does a count check.
  sb_bank #(.NREG(NUM_VREG), .AW(VREG_AW)) u_vbank (
    .clk(clk), .rst(rst),
    .rd1_addr(de_v1_addr), .rd2_addr(de_v2_addr), .rd1_cnt_chk(1'b0),
    .wr_req(de_vwb_en), .wr_addr(de_vwb_addr), .issue(issue & de_vwb_en), .wr_late(de_late),
    .clr_en(mem_v_done), .clr_addr(mem_v_addr),
    .ret_en(wb_vwb_en), .ret_addr(wb_vwb_addr),
    .hazard(v_hazard), .busy_nxt(v_busy), .err_evt(v_err)
  );

  // Busy follows the counters; error is sticky until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_busy_r <= 1'b0;
      sb_err_r  <= 1'b0;
    end else begin
      sb_busy_r <= s_busy | v_busy;
      sb_err_r  <= sb_err_r | s_err | v_err;
    end
  end
endmodule
